// File: rtl/stopwatch_bcd_if.sv
// Control/status bundle between the stopwatch and its driver/display side.
interface stopwatch_bcd_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   q;
    logic                  running;
    logic                  lap_active;
    logic                  ovf;
    logic                  carry;

    modport master (
        output tick, start, stop, clear, lap,
        input  q, running, lap_active, ovf, carry
    );

    modport slave (
        input  tick, start, stop, clear, lap,
        output q, running, lap_active, ovf, carry
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// Tick-driven BCD stopwatch: IDLE/RUN/PAUSED control, lap snapshot hold,
// sticky overflow on wrap from all-9s.
module stopwatch_bcd #(
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t                  state, state_nxt;
    logic                    tick_d;
    logic                    tick_rise;
    logic [DIGITS-1:0][3:0]  cnt, cnt_inc, cnt_nxt, snap;
    logic [DIGITS:0]         low_nines;
    logic                    inc, wrap, lap_take;
    logic                    lap_active, lap_nxt;
    logic                    ovf, carry;

    assign tick_rise = bus.tick & ~tick_d;

    // low_nines[i]: every digit below i reads 9, so digit i steps on increment
    assign low_nines[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign low_nines[i+1] = low_nines[i] & (cnt[i] == 4'd9);
        assign cnt_inc[i]     = !low_nines[i]      ? cnt[i] :
                                (cnt[i] == 4'd9)   ? 4'd0   : cnt[i] + 4'd1;
    end

    assign wrap = inc & low_nines[DIGITS];

    always_comb begin
        state_nxt = state;
        inc       = 1'b0;
        lap_nxt   = lap_active;
        lap_take  = 1'b0;
        cnt_nxt   = cnt;
        if (bus.clear) begin
            state_nxt = IDLE;
            lap_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            // counting follows the state held at this edge, not the requested one
            inc = (state == RUN) & tick_rise;
            if (inc)
                cnt_nxt = cnt_inc;
            if (bus.stop) begin
                if (state == RUN)
                    state_nxt = PAUSED;
                lap_nxt = 1'b0;
            end else if (bus.start) begin
                if (state != RUN)
                    state_nxt = RUN;
            end else if (bus.lap && state == RUN) begin
                lap_nxt  = ~lap_active;
                lap_take = ~lap_active;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_d     <= 1'b1;
            cnt        <= '0;
            snap       <= '0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            carry      <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_d     <= bus.tick;
            cnt        <= cnt_nxt;
            lap_active <= lap_nxt;
            carry      <= wrap;
            ovf        <= bus.clear ? 1'b0 : (ovf | wrap);
            if (bus.clear)
                snap <= '0;
            else if (lap_take)
                snap <= cnt_nxt;
        end
    end

    assign bus.q          = lap_active ? snap : cnt;
    assign bus.running    = (state == RUN);
    assign bus.lap_active = lap_active;
    assign bus.ovf        = ovf;
    assign bus.carry      = carry;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd (DIGITS=4).
module tb_stopwatch_bcd;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    stopwatch_bcd_if #(.DIGITS(4)) bus ();

    stopwatch_bcd #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // tick high for one edge, then low for gap edges
    task automatic tick_pulse(input int gap);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1; step(); bus.clear = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.lap = 1'b1; step(); bus.lap = 1'b0;
    endtask

    function automatic logic digits_ok(input logic [15:0] v);
        logic ok = 1'b1;
        for (int d = 0; d < 4; d++)
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    initial begin
        rst = 1'b1;
        bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.clear = 1'b0; bus.lap = 1'b0;
        #23;
        chk("reset_q",       bus.q,          16'h0000);
        chk("reset_running", {15'd0, bus.running},    16'd0);
        chk("reset_lap",     {15'd0, bus.lap_active}, 16'd0);
        chk("reset_ovf",     {15'd0, bus.ovf},        16'd0);
        chk("reset_carry",   {15'd0, bus.carry},      16'd0);
        step();
        rst = 1'b0;
        step();

        // idle ignores ticks
        tick_pulse(1);
        chk("idle_no_count", bus.q, 16'h0000);

        pulse_start();
        chk("start_running", {15'd0, bus.running}, 16'd1);
        for (int i = 0; i < 12; i++) tick_pulse(3);
        chk("basic_q",       bus.q,                   16'h0012);
        chk("basic_running", {15'd0, bus.running},    16'd1);
        chk("basic_ovf",     {15'd0, bus.ovf},        16'd0);

        for (int i = 0; i < 87; i++) begin
            tick_pulse(1);
            chk("digit_range", {15'd0, digits_ok(bus.q)}, 16'd1);
        end
        chk("to_0099", bus.q, 16'h0099);
        tick_pulse(1);
        chk("decade_carry", bus.q, 16'h0100);

        for (int i = 0; i < 9899; i++) tick_pulse(1);
        chk("to_9999", bus.q, 16'h9999);
        chk("pre_wrap_carry", {15'd0, bus.carry}, 16'd0);
        bus.tick = 1'b1;
        step();
        chk("wrap_q",     bus.q,                16'h0000);
        chk("wrap_carry", {15'd0, bus.carry},   16'd1);
        chk("wrap_ovf",   {15'd0, bus.ovf},     16'd1);
        bus.tick = 1'b0;
        step();
        chk("carry_one_cycle", {15'd0, bus.carry}, 16'd0);
        tick_pulse(1);
        chk("post_wrap_q",   bus.q,            16'h0001);
        chk("ovf_sticky",    {15'd0, bus.ovf}, 16'd1);
        pulse_clear();
        chk("clear_q",       bus.q,                16'h0000);
        chk("clear_ovf",     {15'd0, bus.ovf},     16'd0);
        chk("clear_running", {15'd0, bus.running}, 16'd0);

        // lap hold
        pulse_start();
        for (int i = 0; i < 5; i++) tick_pulse(1);
        chk("lap_pre", bus.q, 16'h0005);
        pulse_lap();
        chk("lap_on", {15'd0, bus.lap_active}, 16'd1);
        for (int i = 0; i < 3; i++) tick_pulse(1);
        chk("lap_frozen_q",  bus.q,                   16'h0005);
        chk("lap_frozen_on", {15'd0, bus.lap_active}, 16'd1);
        pulse_lap();
        chk("lap_release_q",   bus.q,                   16'h0008);
        chk("lap_release_off", {15'd0, bus.lap_active}, 16'd0);
        pulse_lap();
        chk("lap_again_on", {15'd0, bus.lap_active}, 16'd1);
        pulse_stop();
        chk("stop_lap_off", {15'd0, bus.lap_active}, 16'd0);
        chk("stop_lap_q",   bus.q,                   16'h0008);
        chk("stop_paused",  {15'd0, bus.running},    16'd0);
        // lap in PAUSED is ignored
        pulse_lap();
        chk("paused_lap_ignored", {15'd0, bus.lap_active}, 16'd0);

        // coincident events
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 3; i++) tick_pulse(1);
        chk("coin_pre", bus.q, 16'h0003);
        bus.stop = 1'b1; bus.tick = 1'b1;
        step();
        bus.stop = 1'b0; bus.tick = 1'b0;
        chk("stop_tick_q",   bus.q,                16'h0004);
        chk("stop_tick_run", {15'd0, bus.running}, 16'd0);
        step();
        bus.start = 1'b1; bus.tick = 1'b1;
        step();
        bus.start = 1'b0; bus.tick = 1'b0;
        chk("start_tick_q",   bus.q,                16'h0004);
        chk("start_tick_run", {15'd0, bus.running}, 16'd1);
        step();
        bus.clear = 1'b1; bus.start = 1'b1; bus.tick = 1'b1;
        step();
        bus.clear = 1'b0; bus.start = 1'b0; bus.tick = 1'b0;
        chk("clear_start_tick_q",   bus.q,                16'h0000);
        chk("clear_start_tick_run", {15'd0, bus.running}, 16'd0);
        step();
        tick_pulse(1);
        chk("clear_left_idle", bus.q, 16'h0000);

        // stuck tick counts once
        pulse_start();
        bus.tick = 1'b1;
        repeat (20) step();
        bus.tick = 1'b0;
        step();
        chk("stuck_tick", bus.q, 16'h0001);

        // async reset mid-run with lap hold active
        tick_pulse(1);
        pulse_lap();
        chk("pre_rst_q",   bus.q,                   16'h0002);
        chk("pre_rst_lap", {15'd0, bus.lap_active}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_q",       bus.q,                   16'h0000);
        chk("async_rst_running", {15'd0, bus.running},    16'd0);
        chk("async_rst_lap",     {15'd0, bus.lap_active}, 16'd0);
        chk("async_rst_ovf",     {15'd0, bus.ovf},        16'd0);
        bus.tick = 1'b1;
        step();
        rst = 1'b0;
        step();
        pulse_start();
        repeat (3) step();
        chk("rst_tick_high_q",   bus.q,                16'h0000);
        chk("rst_tick_high_run", {15'd0, bus.running}, 16'd1);
        bus.tick = 1'b0;
        step();
        tick_pulse(1);
        chk("after_rst_count", bus.q, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Tick-driven BCD stopwatch that sits directly downstream of the scaled countdown timer. It consumes the timer's `tick` output as its time base and keeps a multi-digit decimal count. Start/stop/clear/lap controls run it through an IDLE/RUN/PAUSED state machine. It presents a registered BCD value for the display driver, plus a sticky overflow flag.

## Interface
- `DIGITS`, default 4: number of BCD decades; count range 0 to 10^DIGITS−1.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  time base from the upstream timer; level input, edge-detected internally.
- `start`  in  1  start/resume request, single-cycle pulse.
- `stop`  in  1  pause request, single-cycle pulse.
- `clear`  in  1  zero count and return to IDLE, single-cycle pulse.
- `lap`  in  1  toggle lap-hold, single-cycle pulse.
- `q`  out  4*DIGITS  displayed BCD value; digit i is `q[4i+3:4i]`, with digit 0 least significant.
- `running`  out  1  high in RUN.
- `lap_active`  out  1  high while `q` shows a frozen lap snapshot.
- `ovf`  out  1  sticky; set on wrap from all-9s to 0.
- `carry`  out  1  one-cycle pulse on the same edge as the wrap.

## Operation
- Reset: state IDLE; count = 0; snapshot = 0; `q`=0, `running`=0, `lap_active`=0, `ovf`=0, `carry`=0; `tick_d` = 1, so a `tick` already high at reset release is not counted.
- Edge detect: `tick_rise = tick & ~tick_d`, where `tick_d` is `tick` registered every cycle regardless of state.
  - An upstream timer held disabled with `tick` stuck high yields one count, not one per cycle.
- States:
  - IDLE: count held at 0.
    - `start` → RUN.
  - RUN: count advances by 1 on `tick_rise`.
    - `stop` → PAUSED.
    - `lap` toggles the lap hold.
  - PAUSED: count held.
    - `start` → RUN.
    - `lap` ignored.
  - `clear` from any state → IDLE.
- Control priority within one cycle: `clear` > `stop` > `start` > `lap`. The lower-priority requests in that cycle are dropped.
  - `start` in RUN is a no-op.
  - `stop` in IDLE or PAUSED is a no-op.
- Counting uses the state at the current edge:
  - `tick_rise` coincident with `start` from IDLE/PAUSED is not counted.
  - `tick_rise` coincident with `stop` in RUN is counted.
  - `tick_rise` coincident with `clear` is discarded; count = 0.
- Increment arithmetic:
  - Digit 0 always steps.
  - Digit i (i>0) steps only when digits 0..i−1 are all 9.
  - A digit at 9 that steps becomes 0. No digit ever holds A–F.
- Wrap: from all-9s, the count goes to all-0s; `ovf` is set and `carry` pulses on the same edge. Counting continues. `ovf` clears only on `clear` or `rst`.
- Lap hold:
  - `lap` in RUN with the hold inactive: snapshot ← the count value after this edge's increment; `lap_active`=1.
  - `lap` with the hold active: `lap_active`=0.
  - `stop` or `clear` forces `lap_active`=0, so a paused display always shows the true count.
  - `lap` coincident with `stop` is dropped by priority.
- Output mux: `q` = `lap_active` ? snapshot : count. Both operands are registered; the mux adds no extra register stage.

## Timing
- Count update: on the first rising `clk` edge that samples `tick`=1 after `tick`=0; `q` reflects it immediately after that edge (latency 1 edge from `tick` assertion).
- Minimum spacing: one `tick_rise` is possible every 2 cycles. A `tick` high for exactly 1 cycle per timer period, as the upstream timer produces, yields exactly one count.
- `running` and `lap_active` are registered and change on the edge that accepts the control pulse.
- `carry` is high for exactly one cycle per wrap.
- Asynchronous reset mid-count: outputs go to reset values immediately, independent of `clk`.

## Test plan
- Basic run: DIGITS=4; reset, `start`, 12 one-cycle `tick` pulses spaced 4 cycles apart → `q`=16'h0012, `running`=1, `ovf`=0.
- Decade carry: run to 16'h0099, one more `tick` → `q`=16'h0100; no digit ever reads above 9 during the sequence.
- Wrap: run to 16'h9999, one `tick` → `q`=16'h0000, `carry`=1 for 1 cycle, `ovf`=1. A further `tick` → `q`=16'h0001, `ovf` still 1. Then `clear` → `ovf`=0, `q`=0, `running`=0.
- Lap hold: at count 16'h0005, pulse `lap`, then 3 more ticks → `q` stays 16'h0005, `lap_active`=1. Pulse `lap` → `q`=16'h0008. Pulse `lap` again, then `stop` → `lap_active`=0, `q`=16'h0008.
- Coincident events:
  - `stop`+`tick_rise` in RUN at 16'h0003 → `q`=16'h0004 and PAUSED.
  - `start`+`tick_rise` in PAUSED → `q` unchanged and RUN.
  - `clear`+`start`+`tick_rise` → `q`=0, IDLE.
- Stuck tick / reset: hold `tick`=1 for 20 cycles in RUN → exactly +1. Assert `rst` asynchronously between clock edges mid-run → all outputs 0 before the next edge. Release `rst` with `tick`=1 → no count after `start`.
